// File: rtl/serial_addsub_st_if.sv
// Handshake/operand bundle for serial_addsub_st.
// The sub signal exists only when SERIAL_SUB_EN is defined.
interface serial_addsub_st_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;

    modport master (
        output start, a, b,
`ifdef SERIAL_SUB_EN
        output sub,
`endif
        input  busy, done, result, cout
    );

    modport slave (
        input  start, a, b,
`ifdef SERIAL_SUB_EN
        input  sub,
`endif
        output busy, done, result, cout
    );
endinterface

// File: rtl/serial_addsub_st.sv
// Bit-serial LSB-first adder: one full-adder cell plus carry flop, WIDTH cycles per op.
// Define SERIAL_SUB_EN to add the sub input (a - b via inverted B and carry-in of 1).
module serial_addsub_st #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_addsub_st_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;

    logic             w_sub;
    logic             w_s;
    logic             w_cy;
    logic [WIDTH-1:0] w_acc_nxt;

`ifdef SERIAL_SUB_EN
    assign w_sub = bus.sub;
`else
    assign w_sub = 1'b0;
`endif

    assign w_s       = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_cy      = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
    // Sum bits enter at the MSB so bit 0 lands at the LSB after WIDTH shifts
    assign w_acc_nxt = {w_s, r_acc[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= w_sub ? ~bus.b : bus.b;
                        r_carry <= w_sub;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_carry <= w_cy;
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_acc   <= w_acc_nxt;
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_result <= w_acc_nxt;
                        r_cout   <= w_cy;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.cout   = r_cout;
endmodule

// File: tb/tb_serial_addsub_st.sv
// Scoreboard bench for serial_addsub_st; subtract cases compile in with SERIAL_SUB_EN.
module tb_serial_addsub_st;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_addsub_st_if #(.WIDTH(W)) bus();
    serial_addsub_st #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;
    logic [W:0] exp_q[$];
    logic [W:0] held;
    bit   mon_en = 1'b0;
    int   cyc = 0;
    int   ndone = 0;
    int   done_cyc = 0;
    int   prev_done_cyc = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
        logic [W-1:0] d;
        if (s) begin
            d = a - b;
            return {(a >= b) ? 1'b1 : 1'b0, d};
        end
        return {1'b0, a} + {1'b0, b};
    endfunction

    task automatic set_sub(input bit s);
`ifdef SERIAL_SUB_EN
        bus.sub = s;
`endif
    endtask

    // Result/cout must hold the last completed value every cycle; done pops the scoreboard
    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            if (bus.done) begin
                ndone++;
                prev_done_cyc = done_cyc;
                done_cyc = cyc;
                check("busy_in_done", bus.busy, 0);
                if (exp_q.size() == 0) check("spurious_done", bus.done, 0);
                else held = exp_q.pop_front();
            end
            check("result", bus.result, held[W-1:0]);
            check("cout", bus.cout, held[W]);
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!bus.busy && !bus.done) return;
        end
        check("idle_timeout", bus.busy | bus.done, 0);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s, input int poke);
        int lat;
        int nb;
        bit got;
        wait_idle();
        bus.a = a;
        bus.b = b;
        set_sub(s);
        bus.start = 1'b1;
        exp_q.push_back(model(a, b, s));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        set_sub(1'($urandom));
        lat = 0;
        nb = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (bus.done) got = 1'b1;
            else if (bus.busy) nb++;
            if (lat == poke) begin
                bus.a = 8'hF0;
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        check("done_seen", got, 1);
        check("latency", lat, W + 1);
        check("busy_cycles", nb, W);
    endtask

    initial begin
        int d0;
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int d0;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        set_sub(1'b0);
        held = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_result", bus.result, 0);
        check("rst_cout", bus.cout, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;

        run_op(8'h5A, 8'h3C, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 0);
        repeat (5) @(negedge clk);
`ifdef SERIAL_SUB_EN
        run_op(8'h10, 8'h01, 1'b1, 0);
        run_op(8'h00, 8'h01, 1'b1, 0);
        run_op(8'h80, 8'h80, 1'b1, 0);
`endif

        // start pulsed mid-RUN must be ignored
        d0 = ndone;
        run_op(8'h01, 8'h02, 1'b0, 3);
        repeat (W + 4) @(negedge clk);
        check("single_done", ndone - d0, 1);

        // reset during bit 4 aborts the operation
        wait_idle();
        bus.a = 8'h77;
        bus.b = 8'h11;
        set_sub(1'b0);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        held = '0;
        d0 = ndone;
        @(negedge clk);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_result", bus.result, 0);
        check("abort_cout", bus.cout, 0);
        repeat (12) @(negedge clk);
        check("abort_no_done", ndone - d0, 0);
        run_op(8'h33, 8'h44, 1'b0, 0);

        // start held high across two operations
        wait_idle();
        d0 = ndone;
        bus.a = 8'hC8;
        bus.b = 8'h64;
        set_sub(1'b0);
        bus.start = 1'b1;
        exp_q.push_back(model(8'hC8, 8'h64, 1'b0));
        @(posedge clk);
        #1;
        bus.a = 8'h12;
        bus.b = 8'h34;
        exp_q.push_back(model(8'h12, 8'h34, 1'b0));
        repeat (W + 2) @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        for (int i = 0; i < 60 && ndone < d0 + 2; i++) @(negedge clk);
        check("b2b_dones", ndone - d0, 2);
        check("b2b_spacing", done_cyc - prev_done_cyc, W + 2);

        for (int i = 0; i < 6; i++) begin
`ifdef SERIAL_SUB_EN
            run_op(W'($urandom), W'($urandom), 1'($urandom), 0);
`else
            run_op(W'($urandom), W'($urandom), 1'b0, 0);
`endif
        end
        repeat (4) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
